// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game control and the mole sprite renderer:
// state encoding, hole geometry and small combinational helpers.
package mole_pkg;

    localparam int         NUM_HOLES = 5;
    localparam logic [2:0] NO_HOLE   = 3'd7;
    localparam int         TIMER_W   = 24;

    typedef logic [TIMER_W-1:0] timer_t;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        UP,
        HIT_HOLD,
        OVER
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } hole_pos_t;

    // Hole centres on the 640x480 playfield, indexed by oval_select.
    function automatic hole_pos_t hole_center(input logic [2:0] hole);
        hole_pos_t pos;
        case (hole)
            3'd0:    pos = '{x: 10'd120, y: 10'd200};
            3'd1:    pos = '{x: 10'd320, y: 10'd200};
            3'd2:    pos = '{x: 10'd520, y: 10'd200};
            3'd3:    pos = '{x: 10'd220, y: 10'd340};
            3'd4:    pos = '{x: 10'd420, y: 10'd340};
            default: pos = '{x: 10'd0,   y: 10'd0};
        endcase
        return pos;
    endfunction

    // Reload value for a down-counter lasting n cycles; a length of 0 behaves as 1.
    function automatic timer_t cycles_to_load(input timer_t n);
        return (n == '0) ? '0 : n - TIMER_W'(1);
    endfunction

    // Fold 3 random bits onto the holes and step past the previous hole.
    function automatic logic [2:0] pick_hole(input logic [2:0] raw, input logic [2:0] prev);
        logic [2:0] c;
        c = (raw >= 3'(NUM_HOLES)) ? raw - 3'(NUM_HOLES) : raw;
        if (c == prev) begin
            c = (c == 3'(NUM_HOLES - 1)) ? 3'd0 : c + 3'd1;
        end
        return c;
    endfunction

    function automatic logic [NUM_HOLES-1:0] hole_mask(input logic [2:0] hole);
        logic [NUM_HOLES-1:0] m;
        for (int i = 0; i < NUM_HOLES; i++) begin
            m[i] = (hole == 3'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Player/HUD-facing bundle of the mole spawner: start and hit buttons in, hole select,
// visibility, hit pulse, score, misses and game-over out.
interface mole_spawner_if;
    import mole_pkg::*;

    logic                 start;
    logic [NUM_HOLES-1:0] hit_btn;
    logic [2:0]           oval_select;
    logic                 mole_visible;
    logic                 hit_pulse;
    logic [7:0]           score;
    logic [3:0]           misses;
    logic                 game_over;

    // master: button logic and HUD/renderer; slave: the spawner itself.
    modport master (
        output start, hit_btn,
        input  oval_select, mole_visible, hit_pulse, score, misses, game_over
    );

    modport slave (
        input  start, hit_btn,
        output oval_select, mole_visible, hit_pulse, score, misses, game_over
    );

endinterface

// File: rtl/mole_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1, stepped every clock.
module mole_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // All-zero is the lock-up state of an XOR LFSR, so a zero seed is replaced.
            r_q <= (seed == 8'd0) ? 8'h01 : seed;
        end else begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole game control: picks the hole, times each mole, detects hits, keeps score/misses.
// Build macro MOLE_DIFFICULTY_RAMP_EN shortens the mole up-time on every 8th hit.
module mole_spawner
    import mole_pkg::*;
#(
    parameter timer_t     UP_CYCLES       = 24'd12_500_000,
    parameter timer_t     GAP_CYCLES      = 24'd6_250_000,
    parameter timer_t     HIT_HOLD_CYCLES = 24'd2_500_000,
    parameter logic [3:0] MAX_MISSES      = 4'd5,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
`ifdef MOLE_DIFFICULTY_RAMP_EN
    ,
    parameter timer_t     UP_STEP         = 24'd625_000,
    parameter timer_t     UP_MIN          = 24'd3_125_000
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mole_spawner_if.slave bus
);

    localparam timer_t GAP_LOAD  = cycles_to_load(GAP_CYCLES);
    localparam timer_t HOLD_LOAD = cycles_to_load(HIT_HOLD_CYCLES);

    state_t     r_state;
    timer_t     r_timer;
    logic [2:0] r_oval_select;
    logic [2:0] r_prev_hole;
    logic       r_mole_visible;
    logic       r_hit_pulse;
    logic [7:0] r_score;
    logic [3:0] r_misses;
    logic       r_game_over;

    logic [7:0] w_lfsr;
    logic [2:0] w_next_hole;
    logic [7:0] w_score_inc;
    logic       w_hit;
    logic       w_timer_done;
    logic       w_last_miss;
    timer_t     w_up_load;

    mole_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    assign w_next_hole  = pick_hole(w_lfsr[2:0], r_prev_hole);
    assign w_score_inc  = (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
    assign w_hit        = |(bus.hit_btn & hole_mask(r_oval_select));
    assign w_timer_done = (r_timer == '0);
    assign w_last_miss  = ((r_misses + 4'd1) == MAX_MISSES);

`ifdef MOLE_DIFFICULTY_RAMP_EN
    timer_t r_up_len;
    timer_t w_up_next;
    logic   w_ramp_step;
    logic   w_restart;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_up_next = UP_MIN;
        if ({1'b0, r_up_len} >= ({1'b0, UP_MIN} + {1'b0, UP_STEP})) begin
            w_up_next = r_up_len - UP_STEP;
        end
    end

    assign w_ramp_step = (w_score_inc[2:0] == 3'd0) && (w_score_inc != 8'd0);
    assign w_restart   = bus.start && ((r_state == IDLE) || (r_state == OVER));
    assign w_up_load   = cycles_to_load(r_up_len);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_up_len <= UP_CYCLES;
        end else if (w_restart) begin
            r_up_len <= UP_CYCLES;
        end else if ((r_state == UP) && w_hit && w_ramp_step) begin
            r_up_len <= w_up_next;
        end
    end
`else
    assign w_up_load = cycles_to_load(UP_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_timer        <= '0;
            r_oval_select  <= NO_HOLE;
            r_prev_hole    <= NO_HOLE;
            r_mole_visible <= 1'b0;
            r_hit_pulse    <= 1'b0;
            r_score        <= 8'd0;
            r_misses       <= 4'd0;
            r_game_over    <= 1'b0;
        end else begin
            r_hit_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state  <= GAP;
                        r_score  <= 8'd0;
                        r_misses <= 4'd0;
                        r_timer  <= GAP_LOAD;
                    end
                end

                GAP: begin
                    if (w_timer_done) begin
                        r_state        <= UP;
                        r_oval_select  <= w_next_hole;
                        r_prev_hole    <= w_next_hole;
                        r_mole_visible <= 1'b1;
                        r_timer        <= w_up_load;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end

                UP: begin
                    // A hit wins over a timeout landing on the same cycle.
                    if (w_hit) begin
                        r_state        <= HIT_HOLD;
                        r_score        <= w_score_inc;
                        r_hit_pulse    <= 1'b1;
                        r_mole_visible <= 1'b0;
                        r_timer        <= HOLD_LOAD;
                    end else if (w_timer_done) begin
                        r_misses       <= r_misses + 4'd1;
                        r_mole_visible <= 1'b0;
                        r_oval_select  <= NO_HOLE;
                        if (w_last_miss) begin
                            r_state     <= OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= GAP;
                            r_timer <= GAP_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end

                HIT_HOLD: begin
                    // The renderer keeps drawing the whacked hole until the hold expires.
                    if (w_timer_done) begin
                        r_state       <= GAP;
                        r_oval_select <= NO_HOLE;
                        r_timer       <= GAP_LOAD;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end

                OVER: begin
                    r_oval_select <= NO_HOLE;
                    if (bus.start) begin
                        r_state     <= GAP;
                        r_score     <= 8'd0;
                        r_misses    <= 4'd0;
                        r_game_over <= 1'b0;
                        r_timer     <= GAP_LOAD;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.oval_select  = r_oval_select;
    assign bus.mole_visible = r_mole_visible;
    assign bus.hit_pulse    = r_hit_pulse;
    assign bus.score        = r_score;
    assign bus.misses       = r_misses;
    assign bus.game_over    = r_game_over;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with short timings (UP=10, GAP=4, HIT_HOLD=3, MAX_MISSES=3).
// Holes are predicted by an independent LFSR model run in lockstep with the clock.
module tb_mole_spawner;

    localparam int         P_UP    = 10;
    localparam int         P_GAP   = 4;
    localparam int         P_HOLD  = 3;
    localparam int         P_MAXM  = 3;
    localparam logic [7:0] P_SEED  = 8'hA5;
    localparam logic [2:0] P_NONE  = 3'd7;

`ifdef MOLE_DIFFICULTY_RAMP_EN
    localparam int EXP_UP_8   = 8;
    localparam int EXP_UP_16  = 6;
    localparam int EXP_UP_24  = 6;
    localparam int EXP_UP_SAT = 6;
`else
    localparam int EXP_UP_8   = 10;
    localparam int EXP_UP_16  = 10;
    localparam int EXP_UP_24  = 10;
    localparam int EXP_UP_SAT = 10;
`endif

    logic clk;
    logic rst;

    int n_vec;
    int n_fail;

    logic [7:0] m_lfsr;
    logic [7:0] m_lfsr_prev;
    logic [2:0] m_hole;
    logic [7:0] m_score;
    logic [3:0] m_misses;

    mole_spawner_if u_if ();

    mole_spawner #(
        .UP_CYCLES       (24'(P_UP)),
        .GAP_CYCLES      (24'(P_GAP)),
        .HIT_HOLD_CYCLES (24'(P_HOLD)),
        .MAX_MISSES      (4'(P_MAXM)),
        .LFSR_SEED       (P_SEED)
`ifdef MOLE_DIFFICULTY_RAMP_EN
        ,
        .UP_STEP         (24'd2),
        .UP_MIN          (24'd6)
`endif
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_pick(input logic [7:0] l, input logic [2:0] prev);
        logic [2:0] c;
        c = l[2:0];
        if (c > 3'd4) c = c - 3'd5;
        if (c == prev) c = (c == 3'd4) ? 3'd0 : c + 3'd1;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; the LFSR model steps exactly when the DUT's does.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_lfsr_prev = m_lfsr;
            m_lfsr      = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end else begin
            m_lfsr_prev = P_SEED;
            m_lfsr      = P_SEED;
        end
        #1;
    endtask

    task automatic start_game(input string tag);
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        m_score  = 8'd0;
        m_misses = 4'd0;
        chk({tag, "_score"}, u_if.score, 0);
        chk({tag, "_misses"}, u_if.misses, 0);
        chk({tag, "_game_over"}, u_if.game_over, 0);
    endtask

    // From the first GAP cycle: hidden for P_GAP cycles, then the predicted hole appears.
    task automatic spawn(input string tag);
        logic [2:0] exp_h;
        repeat (P_GAP - 1) begin
            tick();
            chk({tag, "_gap_hidden"}, u_if.mole_visible, 0);
        end
        tick();
        exp_h = exp_pick(m_lfsr_prev, m_hole);
        chk({tag, "_visible"}, u_if.mole_visible, 1);
        chk({tag, "_hole"}, u_if.oval_select, exp_h);
        chk({tag, "_no_repeat"}, (u_if.oval_select != m_hole), 1);
        m_hole = exp_h;
    endtask

    task automatic hold_out(input string tag);
        repeat (P_HOLD - 1) begin
            tick();
            chk({tag, "_hold_hole"}, u_if.oval_select, m_hole);
        end
        tick();
        chk({tag, "_hold_end"}, u_if.oval_select, P_NONE);
    endtask

    task automatic hit_now(input string tag);
        u_if.hit_btn = 5'd1 << m_hole;
        tick();
        u_if.hit_btn = 5'd0;
        m_score = (m_score == 8'hFF) ? 8'hFF : m_score + 8'd1;
        chk({tag, "_hit_pulse"}, u_if.hit_pulse, 1);
        chk({tag, "_hit_hidden"}, u_if.mole_visible, 0);
        chk({tag, "_hit_score"}, u_if.score, m_score);
        hold_out(tag);
    endtask

    task automatic expire(input string tag, input int exp_up);
        int n;
        n = 0;
        while (u_if.mole_visible === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        m_misses = m_misses + 4'd1;
        chk({tag, "_uptime"}, n, exp_up);
        chk({tag, "_misses"}, u_if.misses, m_misses);
        chk({tag, "_hole_none"}, u_if.oval_select, P_NONE);
        chk({tag, "_game_over"}, u_if.game_over, (m_misses == 4'(P_MAXM)));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_oval"}, u_if.oval_select, P_NONE);
        chk({tag, "_visible"}, u_if.mole_visible, 0);
        chk({tag, "_hit_pulse"}, u_if.hit_pulse, 0);
        chk({tag, "_score"}, u_if.score, 0);
        chk({tag, "_misses"}, u_if.misses, 0);
        chk({tag, "_game_over"}, u_if.game_over, 0);
    endtask

    initial begin
        int wrong;
        n_vec        = 0;
        n_fail       = 0;
        m_lfsr       = P_SEED;
        m_lfsr_prev  = P_SEED;
        m_hole       = P_NONE;
        m_score      = 8'd0;
        m_misses     = 4'd0;
        rst          = 1'b0;
        u_if.start   = 1'b0;
        u_if.hit_btn = 5'd0;

        // Reset state, then idle without start.
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_oval", u_if.oval_select, P_NONE);
        chk("idle_visible", u_if.mole_visible, 0);

        // Game 1: no presses, three expiries end the game.
        start_game("g1_start");
        for (int i = 0; i < P_MAXM; i++) begin
            spawn("g1");
            expire("g1", P_UP);
        end
        repeat (3) tick();
        chk("over_hole", u_if.oval_select, P_NONE);
        chk("over_stays", u_if.game_over, 1);

        // Game 2: hit in the 5th UP cycle.
        start_game("g2_start");
        spawn("g2a");
        repeat (4) tick();
        hit_now("g2a");
        tick();
        chk("pulse_one_cycle", u_if.hit_pulse, 0);
        // the GAP already counted one cycle above, so spawn sees one extra hidden cycle at most
        repeat (P_GAP - 2) begin
            tick();
            chk("g2b_gap_hidden", u_if.mole_visible, 0);
        end
        tick();
        chk("g2b_visible", u_if.mole_visible, 1);
        chk("g2b_hole", u_if.oval_select, exp_pick(m_lfsr_prev, m_hole));
        m_hole = exp_pick(m_lfsr_prev, m_hole);

        // Wrong hole, ignored start, then right hole coincident with the timeout.
        wrong = (int'(m_hole) + 1) % 5;
        u_if.hit_btn = 5'd1 << wrong;
        tick();
        u_if.hit_btn = 5'd0;
        chk("wrong_score", u_if.score, m_score);
        chk("wrong_pulse", u_if.hit_pulse, 0);
        chk("wrong_visible", u_if.mole_visible, 1);
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        chk("start_ignored_vis", u_if.mole_visible, 1);
        chk("start_ignored_score", u_if.score, m_score);
        chk("start_ignored_hole", u_if.oval_select, m_hole);
        repeat (P_UP - 3) tick();
        wrong = (int'(m_hole) + 4) % 5;
        u_if.hit_btn = (5'd1 << m_hole) | (5'd1 << wrong);
        tick();
        u_if.hit_btn = 5'd0;
        m_score = m_score + 8'd1;
        chk("coinc_pulse", u_if.hit_pulse, 1);
        chk("coinc_score", u_if.score, m_score);
        chk("coinc_misses", u_if.misses, 0);
        chk("coinc_visible", u_if.mole_visible, 0);
        hold_out("coinc");

        // Long run of spawns and hits; score saturates at 255.
        for (int i = 0; i < 260; i++) begin
            spawn("run");
            hit_now("run");
        end
        chk("score_saturated", u_if.score, 255);
        for (int i = 0; i < P_MAXM; i++) begin
            spawn("g2_end");
            expire("g2_end", EXP_UP_SAT);
        end

        // Game 3: up-time after hits 8, 16, 24, then a restart.
        start_game("g3_start");
        spawn("g3");
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                hit_now("g3");
                spawn("g3");
            end
            expire((s == 0) ? "g3_after8" : ((s == 1) ? "g3_after16" : "g3_after24"),
                   (s == 0) ? EXP_UP_8 : ((s == 1) ? EXP_UP_16 : EXP_UP_24));
            if (s < 2) spawn("g3");
        end
        start_game("g4_start");
        spawn("g4");
        expire("g4_restart", P_UP);

        // Asynchronous reset in the middle of an UP period.
        spawn("g4b");
        repeat (3) tick();
        #3;
        rst          = 1'b0;
        m_lfsr       = P_SEED;
        m_lfsr_prev  = P_SEED;
        m_hole       = P_NONE;
        m_score      = 8'd0;
        m_misses     = 4'd0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        chk("post_reset_idle_oval", u_if.oval_select, P_NONE);
        chk("post_reset_idle_vis", u_if.mole_visible, 0);
        start_game("g5_start");
        spawn("g5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
